// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration register bank: CTRL layout, commit FSM states
// and the CTRL readback packer.
package cfg_pkg;

    localparam int unsigned CTRL_W    = 8;
    localparam int unsigned CTRL_GO   = 0;
    localparam int unsigned CTRL_SAFE = 1;
    localparam int unsigned CTRL_LOCK = 7;

    typedef enum logic [1:0] {
        CS_IDLE  = 2'd0,
        CS_ARMED = 2'd1,
        CS_APPLY = 2'd2
    } cfg_state_t;

    // CTRL register image as seen on readback
    typedef struct packed {
        logic       lock;
        logic [2:0] rsvd_hi;
        logic       tmo_flag;
        logic       pend_any;
        logic       busy;
        logic       rsvd_lo;
    } cfg_ctrl_t;

    function automatic logic [CTRL_W-1:0] ctrl_pack(
        input logic lock,
        input logic tmo_flag,
        input logic pend_any,
        input logic busy
    );
        cfg_ctrl_t c;
        c          = '0;
        c.lock     = lock;
        c.tmo_flag = tmo_flag;
        c.pend_any = pend_any;
        c.busy     = busy;
        return c;
    endfunction

endpackage

// File: rtl/cfg_commit_fsm.sv
// Commit sequencer: immediate or safe-point commit with optional timeout; owns the
// timeout counter and the sticky-until-rearm timeout flag.
module cfg_commit_fsm
    import cfg_pkg::*;
#(
    parameter int unsigned TMO_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic safe_mode,
    input  logic safe,
    output logic apply,
    output logic busy,
    output logic tmo_flag
);

    localparam int unsigned      CNT_W    = (TMO_CYC == 0) ? 1 : $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             TMO_EN   = (TMO_CYC != 0);

    cfg_state_t       r_state;
    cfg_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tmo;
    logic             w_tmo_nxt;
    logic             r_apply;
    logic             r_busy;
    logic             w_apply_nxt;
    logic             w_busy_nxt;

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CS_IDLE;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
            r_apply <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
            r_apply <= w_apply_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // A GO write wins over every other transition and restarts the counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_tmo_nxt   = r_tmo;
        if (go) begin
            w_state_nxt = safe_mode ? CS_ARMED : CS_APPLY;
            if (safe_mode) begin
                w_tmo_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                CS_ARMED: begin
                    if (safe) begin
                        w_state_nxt = CS_APPLY;
                    end else if (TMO_EN && (r_cnt == CNT_LAST)) begin
                        w_state_nxt = CS_APPLY;
                        w_tmo_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                    end
                end
                CS_APPLY: w_state_nxt = CS_IDLE;
                default:  w_state_nxt = CS_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_state
    always_comb begin
        w_apply_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_apply_nxt = (w_state_nxt == CS_APPLY);
        w_busy_nxt  = (w_state_nxt == CS_ARMED) || (w_state_nxt == CS_APPLY);
    end

    assign apply    = r_apply;
    assign busy     = r_busy;
    assign tmo_flag = r_tmo;

endmodule

// File: rtl/cfg_regbank.sv
// Double-buffered configuration register bank: host writes land in staging registers and a
// commit copies the pending ones to the active set. CTRL readback is built only with CFG_READBACK_EN.
module cfg_regbank
    import cfg_pkg::*;
#(
    parameter int unsigned                  REG_NUM = 8,
    parameter int unsigned                  REG_W   = 8,
    parameter int unsigned                  ADDR_W  = 4,
    parameter logic [REG_NUM*REG_W-1:0]     RST_VAL = '0,
    parameter int unsigned                  TMO_CYC = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [REG_W-1:0]         dati,
    output logic [REG_W-1:0]         dato,
    input  logic                     safe,
    output logic [REG_NUM*REG_W-1:0] cfg_act,
    output logic [REG_NUM-1:0]       cfg_upd,
    output logic                     busy
);

    logic [REG_NUM-1:0][REG_W-1:0] r_stg;
    logic [REG_NUM-1:0][REG_W-1:0] r_act;
    logic [REG_NUM-1:0]            r_pend;
    logic [REG_NUM-1:0]            r_upd;
    logic                          r_lock;

    logic [CTRL_W-1:0]             w_ctrl;
    logic                          w_addr_ctrl;
    logic                          w_ctrl_wr;
    logic                          w_go;
    logic [REG_NUM-1:0]            w_dwr;
    logic                          w_apply;
    logic                          w_busy;
    logic                          w_tmo_flag;

    assign w_ctrl      = CTRL_W'(dati);
    assign w_addr_ctrl = (addr == ADDR_W'(REG_NUM));
    assign w_ctrl_wr   = wr && w_addr_ctrl;
    assign w_go        = w_ctrl_wr && w_ctrl[CTRL_GO];

    // One-hot data write enable; dropped entirely while locked
    always_comb begin
        w_dwr = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            w_dwr[i] = wr && !r_lock && (addr == ADDR_W'(i));
        end
    end

    cfg_commit_fsm #(
        .TMO_CYC (TMO_CYC)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .go        (w_go),
        .safe_mode (w_ctrl[CTRL_SAFE]),
        .safe      (safe),
        .apply     (w_apply),
        .busy      (w_busy),
        .tmo_flag  (w_tmo_flag)
    );

    // Staging/active banks; a write landing in the APPLY cycle stays pending for the next commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg  <= RST_VAL;
            r_act  <= RST_VAL;
            r_pend <= '0;
            r_upd  <= '0;
            r_lock <= 1'b0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (w_dwr[i]) begin
                    r_stg[i] <= dati;
                end
            end
            if (w_apply) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    if (r_pend[i]) begin
                        r_act[i] <= r_stg[i];
                    end
                end
                r_upd  <= r_pend;
                r_pend <= w_dwr;
            end else begin
                r_upd  <= '0;
                r_pend <= r_pend | w_dwr;
            end
            if (w_ctrl_wr && w_ctrl[CTRL_LOCK]) begin
                r_lock <= 1'b1;
            end
        end
    end

    assign cfg_act = r_act;
    assign cfg_upd = r_upd;
    assign busy    = w_busy;

`ifdef CFG_READBACK_EN
    logic [REG_W-1:0] r_dato;
    logic [REG_W-1:0] w_rd_mux;

    always_comb begin
        w_rd_mux = '0;
        if (w_addr_ctrl) begin
            w_rd_mux = REG_W'(ctrl_pack(r_lock, w_tmo_flag, |r_pend, w_busy));
        end
        for (int i = 0; i < REG_NUM; i++) begin
            if (addr == ADDR_W'(i)) begin
                w_rd_mux = r_stg[i];
            end
        end
    end

    // Read data held until the next read strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dato <= '0;
        end else if (rd) begin
            r_dato <= w_rd_mux;
        end
    end

    assign dato = r_dato;
`else
    logic w_unused_rb;

    assign dato        = '0;
    assign w_unused_rb = ^{rd, w_tmo_flag};
`endif

endmodule

// File: tb/tb_cfg_regbank.sv
// Directed bench for cfg_regbank: a per-cycle vector table for immediate/safe commits,
// then hand-written sequences for timeout, APPLY-cycle writes, lock and reset mid-commit.
module tb_cfg_regbank;

    localparam logic [63:0] RV = 64'h0000_0000_005A_0000;
    localparam logic [63:0] A1 = 64'h00A5_0000_005A_3C00;
    localparam logic [63:0] A2 = 64'h00A5_0000_115A_3C00;
    localparam logic [63:0] A3 = 64'h00A5_0000_115A_3C22;
    localparam logic [63:0] A4 = 64'h00A5_7700_115A_3C22;

    logic        clk;
    logic        rst;
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [7:0]  dati;
    logic [7:0]  dato;
    logic        safe;
    logic [63:0] cfg_act;
    logic [7:0]  cfg_upd;
    logic        busy;

    int n_total;
    int n_bad;

    cfg_regbank #(
        .REG_NUM (8),
        .REG_W   (8),
        .ADDR_W  (4),
        .RST_VAL (RV),
        .TMO_CYC (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .rd      (rd),
        .addr    (addr),
        .dati    (dati),
        .dato    (dato),
        .safe    (safe),
        .cfg_act (cfg_act),
        .cfg_upd (cfg_upd),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [7:0]  dati;
        logic        safe;
        logic        exp_busy;
        logic [7:0]  exp_upd;
        logic [63:0] exp_act;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Inputs change on the falling edge, outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [7:0] d);
        wr   = 1'b1;
        addr = a;
        dati = d;
        step();
        wr   = 1'b0;
    endtask

    task automatic chk_rd(input string nm, input logic [3:0] a, input logic [7:0] exp);
        rd   = 1'b1;
        addr = a;
        step();
        rd   = 1'b0;
`ifdef CFG_READBACK_EN
        chk(nm, 64'(dato), 64'(exp));
`else
        chk(nm, 64'(dato), 64'h0);
`endif
    endtask

    task automatic chk_out(input string nm, input logic eb, input logic [7:0] eu, input logic [63:0] ea);
        chk({nm, "_busy"}, 64'(busy), 64'(eb));
        chk({nm, "_upd"}, 64'(cfg_upd), 64'(eu));
        chk({nm, "_act"}, cfg_act, ea);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst  = 1'b1;
        wr   = 1'b0;
        rd   = 1'b0;
        addr = '0;
        dati = '0;
        safe = 1'b0;

        // wr addr dati safe | busy upd act
        vt[0]  = '{1'b1, 4'd1,  8'h3C, 1'b0, 1'b0, 8'h00, RV};
        vt[1]  = '{1'b1, 4'd6,  8'hA5, 1'b0, 1'b0, 8'h00, RV};
        vt[2]  = '{1'b1, 4'd8,  8'h01, 1'b0, 1'b1, 8'h00, RV};
        vt[3]  = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h42, A1};
        vt[4]  = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h00, A1};
        vt[5]  = '{1'b1, 4'd3,  8'h11, 1'b0, 1'b0, 8'h00, A1};
        vt[6]  = '{1'b1, 4'd8,  8'h03, 1'b1, 1'b1, 8'h00, A1};
        vt[7]  = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 8'h00, A1};
        vt[8]  = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 8'h00, A1};
        vt[9]  = '{1'b0, 4'd0,  8'h00, 1'b1, 1'b1, 8'h00, A1};
        vt[10] = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h08, A2};
        vt[11] = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h00, A2};
        vt[12] = '{1'b1, 4'd8,  8'h01, 1'b0, 1'b1, 8'h00, A2};
        vt[13] = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h00, A2};
        vt[14] = '{1'b1, 4'd9,  8'hFF, 1'b0, 1'b0, 8'h00, A2};
        vt[15] = '{1'b1, 4'd8,  8'h01, 1'b0, 1'b1, 8'h00, A2};
        vt[16] = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h00, A2};

        step();
        step();
        rst = 1'b0;
        chk_out("reset", 1'b0, 8'h00, RV);
        chk("reset_dato", 64'(dato), 64'h0);

        for (int i = 0; i < NV; i++) begin
            wr   = vt[i].wr;
            addr = vt[i].addr;
            dati = vt[i].dati;
            safe = vt[i].safe;
            step();
            wr   = 1'b0;
            safe = 1'b0;
            chk_out($sformatf("vec%0d", i), vt[i].exp_busy, vt[i].exp_upd, vt[i].exp_act);
        end

        // Safe-mode commit with no safe strobe: timeout after 16 armed cycles
        do_wr(4'd0, 8'h22);
        do_wr(4'd8, 8'h03);
        chk("tmo_arm_busy", 64'(busy), 64'h1);
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 15) chk_out("tmo_k15", 1'b1, 8'h00, A2);
            if (k == 16) chk_out("tmo_k16", 1'b1, 8'h00, A2);
            if (k == 17) chk_out("tmo_k17", 1'b0, 8'h01, A3);
        end
        chk_rd("tmo_flag_set", 4'd8, 8'h08);
        do_wr(4'd8, 8'h03);
        chk_rd("tmo_flag_clr", 4'd8, 8'h02);
        // GO while armed switches to an immediate commit
        do_wr(4'd8, 8'h01);
        chk("rego_busy", 64'(busy), 64'h1);
        step();
        chk_out("rego_done", 1'b0, 8'h00, A3);

        // Write landing in the APPLY cycle stays pending for the next commit
        do_wr(4'd8, 8'h01);
        do_wr(4'd5, 8'h77);
        chk_out("wr_in_apply", 1'b0, 8'h00, A3);
        chk_rd("pend_after_apply", 4'd8, 8'h04);
        chk_rd("rd_reg5", 4'd5, 8'h77);
        do_wr(4'd8, 8'h01);
        step();
        chk_out("apply_reg5", 1'b0, 8'h20, A4);

        // Lock: later data writes dropped, commits still run
        do_wr(4'd8, 8'h80);
        chk("lock_no_go", 64'(busy), 64'h0);
        do_wr(4'd4, 8'hFF);
        do_wr(4'd8, 8'h01);
        step();
        chk_out("locked_commit", 1'b0, 8'h00, A4);
        chk_rd("locked_stg4", 4'd4, 8'h00);
        chk_rd("lock_bit", 4'd8, 8'h80);

        // Reset clears lock; reset mid-commit loses the armed commit
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("rst2", 1'b0, 8'h00, RV);
        chk_rd("lock_cleared", 4'd8, 8'h00);
        do_wr(4'd7, 8'h99);
        do_wr(4'd8, 8'h03);
        chk("mid_arm_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("mid_rst", 1'b0, 8'h00, RV);
        safe = 1'b1;
        step();
        safe = 1'b0;
        step();
        chk_out("mid_rst_safe", 1'b0, 8'h00, RV);
        chk_rd("mid_rst_stg7", 4'd7, 8'h00);
        chk_rd("mid_rst_ctrl", 4'd8, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
